// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PC, instruction register, status flags, halt tracking
// Optional taken-branch counter enabled by defining BR_COUNT_EN.
module fetch_unit (
   input  logic        clk,
   input  logic        rst_f,
   input  logic        pc_rst,
   input  logic        pc_write,
   input  logic        pc_sel,
   input  logic        br_sel,
   input  logic        ir_load,
   input  logic [31:0] imem_data,
   input  logic [3:0]  stat_in,
   input  logic        stat_en,
   output logic [15:0] pc_out,
   output logic [31:0] ir,
   output logic [3:0]  opcode,
   output logic [3:0]  mm,
   output logic [3:0]  stat,
   output logic        halted
`ifdef BR_COUNT_EN
   ,
   output logic [15:0] br_taken_cnt
`endif
);

   typedef enum logic {IDLE = 1'b0, LOADED = 1'b1} track_t;

   track_t      r_state;
   logic [15:0] r_pc;
   logic [31:0] r_ir;
   logic [3:0]  r_stat;
   logic        r_halted;

   logic [31:0] w_ir;
   logic [15:0] w_target;
   logic [15:0] w_next_pc;
   logic        w_pc_upd;
   logic        w_ir_upd;

   // The held word is only visible after a fetch; before that the core sees a NOOP.
   assign w_ir      = (r_state == LOADED) ? r_ir : 32'h0;
   assign w_target  = br_sel ? w_ir[15:0] : (r_pc + w_ir[15:0]);
   assign w_next_pc = pc_sel ? w_target : (r_pc + 16'd1);
   assign w_pc_upd  = pc_write && !r_halted;
   assign w_ir_upd  = ir_load && !r_halted;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         r_state  <= IDLE;
         r_pc     <= 16'h0;
         r_ir     <= 32'h0;
         r_stat   <= 4'h0;
         r_halted <= 1'b0;
      end else begin
         if (pc_rst)
            r_pc <= 16'h0;
         else if (w_pc_upd)
            r_pc <= w_next_pc;

         if (w_ir_upd)
            r_ir <= imem_data;

         if (stat_en)
            r_stat <= stat_in;

         case (r_state)
            IDLE:    if (!pc_rst && w_ir_upd) r_state <= LOADED;
            LOADED:  if (pc_rst) r_state <= IDLE;
            default: r_state <= IDLE;
         endcase

         // Halt is taken from the registered word, so it rises one cycle after capture.
         if (pc_rst)
            r_halted <= 1'b0;
         else if (w_ir[31:28] == 4'hF)
            r_halted <= 1'b1;
      end
   end

`ifdef BR_COUNT_EN
   logic [15:0] r_br_cnt;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f)
         r_br_cnt <= 16'h0;
      else if (pc_write && pc_sel && !r_halted && (r_br_cnt != 16'hFFFF))
         r_br_cnt <= r_br_cnt + 16'd1;
   end

   assign br_taken_cnt = r_br_cnt;
`endif

   assign pc_out = r_pc;
   assign ir     = w_ir;
   assign opcode = w_ir[31:28];
   assign mm     = w_ir[27:24];
   assign stat   = r_stat;
   assign halted = r_halted;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit
module tb_fetch_unit;

   logic        clk;
   logic        rst_f;
   logic        pc_rst, pc_write, pc_sel, br_sel, ir_load;
   logic [31:0] imem_data;
   logic [3:0]  stat_in;
   logic        stat_en;
   logic [15:0] pc_out;
   logic [31:0] ir;
   logic [3:0]  opcode, mm, stat;
   logic        halted;
`ifdef BR_COUNT_EN
   logic [15:0] br_taken_cnt;
`endif

   logic [31:0] imem [0:255];
   int          n_checks;
   int          n_errors;

   fetch_unit dut (
      .clk       (clk),
      .rst_f     (rst_f),
      .pc_rst    (pc_rst),
      .pc_write  (pc_write),
      .pc_sel    (pc_sel),
      .br_sel    (br_sel),
      .ir_load   (ir_load),
      .imem_data (imem_data),
      .stat_in   (stat_in),
      .stat_en   (stat_en),
      .pc_out    (pc_out),
      .ir        (ir),
      .opcode    (opcode),
      .mm        (mm),
      .stat      (stat),
      .halted    (halted)
`ifdef BR_COUNT_EN
      ,
      .br_taken_cnt (br_taken_cnt)
`endif
   );

   assign imem_data = imem[pc_out[7:0]];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic pr, input logic pw, input logic ps, input logic bs, input logic il);
      pc_rst   = pr;
      pc_write = pw;
      pc_sel   = ps;
      br_sel   = bs;
      ir_load  = il;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      for (int i = 0; i < 256; i++) imem[i] = 32'h0;
      imem[0]    = 32'h8012_3000;
      imem[5]    = 32'h1200_FFFE;
      imem[3]    = 32'h2300_0040;
      imem[8'h40] = 32'h3000_0010;
      imem[8'h80] = 32'h4000_FFFF;
      imem[1]    = 32'hF000_0000;
      rst_f   = 1'b0;
      stat_in = 4'h0;
      stat_en = 1'b0;
      drive(0, 0, 0, 0, 0);

      #12;
      check_val("rst_pc", {16'h0, pc_out}, 32'h0);
      check_val("rst_ir", ir, 32'h0);
      check_val("rst_stat", {28'h0, stat}, 32'h0);
      check_val("rst_halted", {31'h0, halted}, 32'h0);
      rst_f = 1'b1;

      drive(1, 0, 0, 0, 0); tick();
      check_val("pcrst_pc", {16'h0, pc_out}, 32'h0);

      drive(0, 1, 0, 0, 1); tick();
      check_val("fetch_pc", {16'h0, pc_out}, 32'h1);
      check_val("fetch_ir", ir, 32'h8012_3000);
      check_val("fetch_opcode", {28'h0, opcode}, 32'h8);
      check_val("fetch_mm", {28'h0, mm}, 32'h0);

      drive(0, 1, 0, 0, 0);
      repeat (4) tick();
      check_val("step_pc", {16'h0, pc_out}, 32'h5);

      drive(0, 0, 0, 0, 1); tick();
      check_val("ld5_ir", ir, 32'h1200_FFFE);
      check_val("ld5_mm", {28'h0, mm}, 32'h2);
      drive(0, 1, 1, 0, 0); tick();
      check_val("rel_br_pc", {16'h0, pc_out}, 32'h3);

      drive(0, 0, 0, 0, 1); tick();
      drive(0, 1, 1, 1, 0); tick();
      check_val("abs_br_pc", {16'h0, pc_out}, 32'h40);

      // Capture and relative branch on the same edge: branch uses the old word.
      drive(0, 1, 1, 0, 1); tick();
      check_val("simul_pc", {16'h0, pc_out}, 32'h80);
      check_val("simul_ir", ir, 32'h3000_0010);
`ifdef BR_COUNT_EN
      check_val("br_cnt3", {16'h0, br_taken_cnt}, 32'h3);
`endif

      drive(0, 0, 0, 0, 1); tick();
      drive(0, 1, 1, 1, 0); tick();
      check_val("to_ffff_pc", {16'h0, pc_out}, 32'hFFFF);
      drive(0, 1, 0, 0, 0); tick();
      check_val("wrap_pc", {16'h0, pc_out}, 32'h0);

      drive(0, 0, 0, 0, 0);
      stat_in = 4'b1010; stat_en = 1'b0; tick();
      check_val("stat_hold", {28'h0, stat}, 32'h0);
      stat_en = 1'b1; tick();
      check_val("stat_load", {28'h0, stat}, 32'hA);
      stat_in = 4'h3; tick();
      stat_en = 1'b0; stat_in = 4'hC; tick();
      check_val("stat_3", {28'h0, stat}, 32'h3);

      drive(0, 1, 0, 0, 0); tick();
      drive(0, 0, 0, 0, 1); tick();
      check_val("hlt_ir", ir, 32'hF000_0000);
      drive(0, 0, 0, 0, 0); tick();
      check_val("halted_set", {31'h0, halted}, 32'h1);
      imem[1] = 32'h5555_0000;
      drive(0, 1, 1, 0, 1); tick();
      drive(0, 1, 0, 0, 1); tick();
      check_val("halt_pc_hold", {16'h0, pc_out}, 32'h1);
      check_val("halt_ir_hold", ir, 32'hF000_0000);
`ifdef BR_COUNT_EN
      check_val("halt_cnt_hold", {16'h0, br_taken_cnt}, 32'h4);
`endif
      drive(1, 0, 0, 0, 0); tick();
      check_val("unhalt", {31'h0, halted}, 32'h0);
      check_val("unhalt_pc", {16'h0, pc_out}, 32'h0);
      check_val("unhalt_ir_idle", ir, 32'h0);
      drive(0, 0, 0, 0, 0); tick();
      check_val("unhalt_stays", {31'h0, halted}, 32'h0);
      check_val("pcrst_keeps_stat", {28'h0, stat}, 32'h3);

      imem[0] = 32'h6000_0012;
      drive(0, 0, 0, 0, 1); tick();
      drive(0, 1, 1, 1, 0); tick();
      check_val("pre_async_pc", {16'h0, pc_out}, 32'h12);
      drive(0, 1, 0, 0, 0);
      #3 rst_f = 1'b0;
      #1;
      check_val("async_pc", {16'h0, pc_out}, 32'h0);
      check_val("async_ir", ir, 32'h0);
      check_val("async_stat", {28'h0, stat}, 32'h0);
      check_val("async_halted", {31'h0, halted}, 32'h0);
`ifdef BR_COUNT_EN
      check_val("async_cnt", {16'h0, br_taken_cnt}, 32'h0);
`endif
      #1 rst_f = 1'b1;
      tick();
      check_val("post_rst_pc", {16'h0, pc_out}, 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_f.
REQ-002 clk  in  1  rising-edge system clock.
REQ-003 rst_f  in  1  asynchronous active-low reset.
REQ-004 pc_rst  in  1  synchronous PC clear request from the control FSM.
REQ-005 pc_write  in  1  PC update enable.
REQ-006 pc_sel  in  1  0 = PC+1, 1 = branch target.
REQ-007 br_sel  in  1  0 = relative target (PC + offset), 1 = absolute target (0 + offset).
REQ-008 ir_load  in  1  instruction register load enable.
REQ-009 imem_data  in  32  combinational instruction memory read data at address pc_out.
REQ-010 stat_in  in  4  condition codes from the ALU.
REQ-011 stat_en  in  1  status register load enable (asserted by the control FSM in execute).
REQ-012 pc_out  out  16  current PC; drives the instruction memory address.
REQ-013 ir  out  32  instruction register.
REQ-014 opcode  out  4  ir[31:28].
REQ-015 mm  out  4  ir[27:24].
REQ-016 stat  out  4  registered condition codes.
REQ-017 halted  out  1  sticky flag; set once HLT (opcode 4'hF) has been loaded.
REQ-018 br_taken_cnt  out  16  count of taken branches; present only when BR_COUNT_EN is defined.

Function
REQ-019 Branch target: br_sel=1 gives target = ir[15:0]; br_sel=0 gives target = pc_out + ir[15:0], computed modulo 2^16.
REQ-020 Next PC: pc_sel=0 gives pc_out+1 with wrap from 16'hFFFF to 16'h0000; pc_sel=1 gives the branch target.
REQ-021 PC update priority on each rising edge: pc_rst (PC <= 0) first, then pc_write (PC <= next PC), otherwise hold.
REQ-022 When ir_load=1 on a rising edge, ir SHALL capture imem_data at the pre-update pc_out; a simultaneous pc_write SHALL NOT affect the captured word.
REQ-023 The ir register SHALL hold its value while ir_load=0.
REQ-024 opcode and mm SHALL be purely combinational slices of ir, giving zero added latency.
REQ-025 The stat register SHALL load stat_in on a rising edge with stat_en=1 and hold otherwise.
REQ-026 The halted flag SHALL set in the cycle after ir captures a word with bits [31:28] = 4'hF.
REQ-027 Once halted=1, pc_write and ir_load SHALL be ignored until reset; pc_rst SHALL still clear the PC and halted.
REQ-028 The block SHALL contain a 2-state tracker (IDLE, LOADED) that distinguishes pre-fetch from post-fetch.
REQ-029 Tracker transition: IDLE to LOADED on ir_load.
REQ-030 Tracker transition: LOADED to IDLE on pc_rst.
REQ-031 While the tracker is IDLE, ir SHALL read 32'h0 (NOOP).

Reset
REQ-032 On rst_f=0, asynchronously and independent of clk: pc_out=0, ir=0, stat=0, halted=0, br_taken_cnt=0, tracker=IDLE.
REQ-033 Reset asserted mid-operation SHALL abort any pending update; the first rising edge after rst_f rises SHALL behave as a normal cycle.
REQ-034 pc_rst SHALL clear pc_out, halted and the tracker only; it SHALL NOT clear ir, stat or br_taken_cnt.

Configuration
REQ-035 Macro BR_COUNT_EN: when defined, br_taken_cnt SHALL increment by 1 on each edge where pc_write=1, pc_sel=1 and halted=0, saturating at 16'hFFFF.
REQ-036 When BR_COUNT_EN is not defined, the br_taken_cnt port and its counter SHALL be absent.

Verification
REQ-037 Reset-then-fetch: pulse rst_f low, then pc_rst=1 for one cycle, then ir_load=1 and pc_write=1 with imem[0]=32'h8012_3000 -> pc_out=1, ir=32'h8012_3000, opcode=8, mm=0.
REQ-038 Relative branch: pc_out=16'h0005, ir[15:0]=16'hFFFE, pc_sel=1, br_sel=0, pc_write=1 -> pc_out=16'h0003.
REQ-039 Absolute branch and PC wrap: ir[15:0]=16'h0040, br_sel=1, pc_sel=1 -> pc_out=16'h0040; separately, pc_out=16'hFFFF with pc_sel=0 -> pc_out=16'h0000.
REQ-040 Status register: stat_in=4'b1010 with stat_en=0 -> stat unchanged; with stat_en=1 -> stat=4'b1010 on the next edge.
REQ-041 Halt: load 32'hF000_0000 -> halted=1; subsequent pc_write and ir_load pulses -> pc_out and ir unchanged; pc_rst -> halted=0, pc_out=0.
REQ-042 Async reset: assert rst_f mid-cycle with pc_out=16'h0012 and stat=4'h3 -> all outputs 0 immediately, before the next clk edge; with BR_COUNT_EN defined, 3 taken branches -> br_taken_cnt=3.
